counter_datapath: RTL

Datapath for the dedicated-processor counter. It sits directly downstream of the counter control unit and takes its AsrcSel/ALoad/OutBufSel strobes. It holds the A register, the incrementer, the A < LIMIT comparator (returned to the control unit as ALt10) and a registered output buffer. Toward the display and bench side it adds a change-detecting out_valid strobe, an emitted-value counter, and sticky done/overflow flags.

---
 rtl/counter_datapath.sv | 103 ++++++++++
 1 files changed

// File: rtl/counter_datapath.sv
// counter_datapath -- datapath half of the dedicated-processor counter.
//
// Holds the A register and its incrementer, the A < LIMIT comparator fed
// back to the control unit, and a registered output buffer. On the display
// side it adds a change-detecting out_valid strobe, a saturating count of
// emitted values, and sticky done/overflow flags.
//
// Parameters
//   WIDTH      width of A, out_data and emit_count
//   LIMIT      unsigned compare bound for ALt10 (1 <= LIMIT <= 2^WIDTH-1)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   AsrcSel    A source: 0 = constant 0, 1 = A+1
//   ALoad      load enable for A
//   OutBufSel  capture A into the output buffer
//   ALt10      combinational (A < LIMIT)
//   out_data   output buffer register
//   out_valid  one-cycle pulse after out_data took a new value
//   emit_count saturating count of out_valid pulses since reset/clear
//   done       sticky: a capture happened while A >= LIMIT
//   overflow   sticky: A wrapped past 2^WIDTH-1
module counter_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             AsrcSel,
  input  logic             ALoad,
  input  logic             OutBufSel,
  output logic             ALt10,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] emit_count,
  output logic             done,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] a;
  logic             primed;
  logic             clr;
  logic             inc;
  logic             new_cap;

  always_comb begin
    clr     = ALoad & ~AsrcSel;
    inc     = ALoad & AsrcSel;
    ALt10   = (a < LIM);
    // A capture is only worth announcing if it follows reset/clear or
    // actually changes the buffer; a clear in the same cycle suppresses it.
    new_cap = OutBufSel & ~clr & (primed | (a != out_data));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a          <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      emit_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      primed     <= 1'b1;
    end else begin
      if (clr) begin
        a <= '0;
      end else if (inc) begin
        a <= a + 1'b1;
      end

      // Buffer always takes the pre-update A, even during a clear.
      if (OutBufSel) begin
        out_data <= a;
      end

      out_valid <= new_cap;

      if (clr) begin
        emit_count <= '0;
        done       <= 1'b0;
        overflow   <= 1'b0;
        primed     <= 1'b1;
      end else begin
        if (new_cap && (emit_count != '1)) begin
          emit_count <= emit_count + 1'b1;
        end
        if (OutBufSel && !ALt10) begin
          done <= 1'b1;
        end
        if (inc && (a == '1)) begin
          overflow <= 1'b1;
        end
        if (OutBufSel) begin
          primed <= 1'b0;
        end
      end
    end
  end

endmodule
